// File: rtl/regf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : regf_wb_arb
// Description : Register-file writeback arbiter with pending-write scoreboard.
//               Two writeback sources (ALU and load unit) compete for a single
//               register-file write port C. A granted request is registered and
//               written one clock later. A per-register pending bit is set by
//               decode (mark) and cleared when the write for that register
//               reaches port C. Decode source checks see a write-through
//               bypass, so a register being written this cycle is not busy.
//
//               Build option:
//                 WB_RR_ARB_EN  defined   -> round-robin between ALU and load
//                               undefined -> fixed priority, ALU always wins
//
// Ports       : clk, reset              clock, synchronous active-high reset
//               halt                    stall grants and marks
//               alu_req/addr/data       ALU writeback request
//               alu_gnt                 ALU request accepted this cycle
//               ld_req/addr/data        load writeback request
//               ld_gnt                  load request accepted this cycle
//               mark_en, mark_addr      set a destination pending
//               rd_addra, rd_addrb      decode source addresses
//               busy_a, busy_b          source still pending
//               addrc, dc, wec          registered write port C
//               pend_vec                scoreboard state
// Revision    : 1.0 - initial release
// ============================================================================
module regf_wb_arb #(
   parameter int WIDTH = 5,
   parameter int SIZE  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             halt,
   input  logic             alu_req,
   input  logic [WIDTH-1:0] alu_addr,
   input  logic [31:0]      alu_data,
   output logic             alu_gnt,
   input  logic             ld_req,
   input  logic [WIDTH-1:0] ld_addr,
   input  logic [31:0]      ld_data,
   output logic             ld_gnt,
   input  logic             mark_en,
   input  logic [WIDTH-1:0] mark_addr,
   input  logic [WIDTH-1:0] rd_addra,
   input  logic [WIDTH-1:0] rd_addrb,
   output logic             busy_a,
   output logic             busy_b,
   output logic [WIDTH-1:0] addrc,
   output logic [31:0]      dc,
   output logic             wec,
   output logic [SIZE-1:0]  pend_vec
);

   logic             w_alu_gnt;
   logic             w_ld_gnt;
   logic [WIDTH-1:0] w_wr_addr;
   logic [31:0]      w_wr_data;
   logic [SIZE-1:0]  w_set;
   logic [SIZE-1:0]  w_clr;
   logic [SIZE-1:0]  w_hit_a;
   logic [SIZE-1:0]  w_hit_b;

   logic             r_wec;
   logic [WIDTH-1:0] r_addrc;
   logic [31:0]      r_dc;
   logic [SIZE-1:0]  r_pend;

`ifdef WB_RR_ARB_EN
   // 0 prefers the ALU, 1 prefers the load unit.
   logic r_rr_ptr;
`endif

   // ------------------------------------------------------------------------
   // Grant logic: reset and halt suppress every grant.
   // ------------------------------------------------------------------------
   always_comb begin
      w_alu_gnt = 1'b0;
      w_ld_gnt  = 1'b0;
      if (!reset && !halt) begin
`ifdef WB_RR_ARB_EN
         if (alu_req && ld_req) begin
            w_alu_gnt = ~r_rr_ptr;
            w_ld_gnt  = r_rr_ptr;
         end else begin
            w_alu_gnt = alu_req;
            w_ld_gnt  = ld_req;
         end
`else
         w_alu_gnt = alu_req;
         w_ld_gnt  = ld_req & ~alu_req;
`endif
      end
   end

`ifdef WB_RR_ARB_EN
   // Only a contested grant moves the pointer, and it moves to the loser.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= 1'b0;
      end else if (w_alu_gnt && ld_req) begin
         r_rr_ptr <= 1'b1;
      end else if (w_ld_gnt && alu_req) begin
         r_rr_ptr <= 1'b0;
      end
   end
`endif

   assign w_wr_addr = w_ld_gnt ? ld_addr : alu_addr;
   assign w_wr_data = w_ld_gnt ? ld_data : alu_data;

   // ------------------------------------------------------------------------
   // Write port C: one-cycle registered stage; addr/data hold when idle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wec   <= 1'b0;
         r_addrc <= '0;
         r_dc    <= '0;
      end else begin
         r_wec <= w_alu_gnt | w_ld_gnt;
         if (w_alu_gnt || w_ld_gnt) begin
            r_addrc <= w_wr_addr;
            r_dc    <= w_wr_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scoreboard. Clears come from the write already on port C, so they still
   // happen during halt; marks are dropped during halt. Set beats clear.
   // ------------------------------------------------------------------------
   always_comb begin
      w_set   = '0;
      w_clr   = '0;
      w_hit_a = '0;
      w_hit_b = '0;
      for (int i = 0; i < SIZE; i++) begin
         w_set[i]   = mark_en & ~halt & (mark_addr == WIDTH'(i));
         w_clr[i]   = r_wec & (r_addrc == WIDTH'(i));
         w_hit_a[i] = (rd_addra == WIDTH'(i));
         w_hit_b[i] = (rd_addrb == WIDTH'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
      end
   end

   // A register being written on port C this cycle is forwarded by the
   // register file, so it is not reported busy.
   assign busy_a = (|(r_pend & w_hit_a)) & ~(r_wec & (r_addrc == rd_addra));
   assign busy_b = (|(r_pend & w_hit_b)) & ~(r_wec & (r_addrc == rd_addrb));

   assign alu_gnt  = w_alu_gnt;
   assign ld_gnt   = w_ld_gnt;
   assign addrc    = r_addrc;
   assign dc       = r_dc;
   assign wec      = r_wec;
   assign pend_vec = r_pend;

endmodule
`default_nettype wire
